// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, MIPS opcode/funct
// values, Ula32 selectors and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      RST_ST    = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_RD    = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WR    = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ADDI_EXEC = 4'd11,
      ADDI_WB   = 4'd12,
      EXCEPTION = 4'd13,
      HALT      = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_HALT = 6'h0D;

   localparam logic [2:0] ULA_ADD = 3'b001;
   localparam logic [2:0] ULA_SUB = 3'b010;
   localparam logic [2:0] ULA_AND = 3'b011;
   localparam logic [2:0] ULA_XOR = 3'b110;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] MTR_ALUOUT = 2'b00;
   localparam logic [1:0] MTR_MDR    = 2'b01;

   function automatic logic isAluFunct(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
   endfunction

   function automatic logic [2:0] ulaFromFunct(input logic [5:0] f);
      case (f)
         FN_SUB:  return ULA_SUB;
         FN_AND:  return ULA_AND;
         FN_XOR:  return ULA_XOR;
         default: return ULA_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state; flags the last
// allowed cycle when ready is still low. TIMEOUT=0 never expires.
module mem_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic active,
   input  logic ready,
   output logic expired
);

   localparam int CW = (TW < 1) ? 1 : TW;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (active && !ready)
         count <= count + CW'(1);
   end

   // Ready in the last cycle wins over the timeout.
   assign expired = (TIMEOUT != 0) && active && !ready && (count == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset controller with variable-latency memory handshake,
// wait-state timeout, addi path, sticky exception flag and halt.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TW      = $clog2(TIMEOUT + 1),
   parameter int STW     = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [5:0]     opcode,
   input  logic [5:0]     funct,
   input  logic           alu_zero,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           mem_wr,
   output logic           iord,
   output logic           ir_write,
   output logic           mdr_write,
   output logic           pc_load,
   output logic [1:0]     pc_source,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_op,
   output logic           alu_out_write,
   output logic           write_a,
   output logic           write_b,
   output logic           reg_write,
   output logic           reg_dst,
   output logic [1:0]     mem_to_reg,
   output logic           error,
   output logic [STW-1:0] estado
);

   state_t state, stateNext;
   logic   waitActive, waitClear, waitExpired;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RST_ST;
         error <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == EXCEPTION)
            error <= 1'b1;
      end
   end

   // Any state change restarts the wait count, so every memory state starts at 0.
   assign waitActive = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign waitClear  = (stateNext != state);

   mem_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) uTimer (
      .clk     (clk),
      .reset   (reset),
      .clear   (waitClear),
      .active  (waitActive),
      .ready   (mem_ready),
      .expired (waitExpired)
   );

   always_comb begin
      stateNext     = state;
      mem_req       = 1'b0;
      mem_wr        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      pc_load       = 1'b0;
      pc_source     = PCS_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = 3'b000;
      alu_out_write = 1'b0;
      write_a       = 1'b0;
      write_b       = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = MTR_ALUOUT;
      case (state)
         RST_ST: stateNext = FETCH;
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ULA_ADD;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_load   = 1'b1;
               stateNext = DECODE;
            end else if (waitExpired) begin
               stateNext = EXCEPTION;
            end
         end
         DECODE: begin
            write_a       = 1'b1;
            write_b       = 1'b1;
            alu_src_b     = SRCB_IMMSH;
            alu_op        = ULA_ADD;
            alu_out_write = 1'b1;
            case (opcode)
               OP_RTYPE: begin
                  if (isAluFunct(funct))    stateNext = R_EXEC;
                  else if (funct == FN_HALT) stateNext = HALT;
                  else                       stateNext = EXCEPTION;
               end
               OP_LW, OP_SW: stateNext = MEM_ADDR;
               OP_BEQ:       stateNext = BRANCH;
               OP_J:         stateNext = JUMP;
               OP_ADDI:      stateNext = ADDI_EXEC;
               default:      stateNext = EXCEPTION;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_IMM;
            alu_op        = ULA_ADD;
            alu_out_write = 1'b1;
            stateNext     = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               mdr_write = 1'b1;
               stateNext = MEM_WB;
            end else if (waitExpired) begin
               stateNext = EXCEPTION;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = MTR_MDR;
            stateNext  = FETCH;
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_wr  = 1'b1;
            iord    = 1'b1;
            if (mem_ready)        stateNext = FETCH;
            else if (waitExpired) stateNext = EXCEPTION;
         end
         R_EXEC: begin
            alu_src_a     = 1'b1;
            alu_op        = ulaFromFunct(funct);
            alu_out_write = 1'b1;
            stateNext     = R_WB;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            stateNext = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ULA_SUB;
            pc_source = PCS_ALUOUT;
            pc_load   = alu_zero;
            stateNext = FETCH;
         end
         JUMP: begin
            pc_source = PCS_JUMP;
            pc_load   = 1'b1;
            stateNext = FETCH;
         end
         ADDI_EXEC: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_IMM;
            alu_op        = ULA_ADD;
            alu_out_write = 1'b1;
            stateNext     = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
            stateNext = FETCH;
         end
         EXCEPTION: stateNext = HALT;
         HALT:      stateNext = HALT;
         default:   stateNext = RST_ST;
      endcase
   end

   assign estado = STW'(state);

endmodule

// File: tb/tb_mc_control_unit.sv
// Instruction-level trace model: each instruction expands into the expected
// per-cycle state/strobe sequence, replayed against the DUT with random waits.
module tb_mc_control_unit;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'h00, funct = 6'h20;
   logic       alu_zero = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_wr, iord, ir_write, mdr_write, pc_load;
   logic [1:0] pc_source, alu_src_b, mem_to_reg;
   logic       alu_src_a, alu_out_write, write_a, write_b, reg_write, reg_dst, error;
   logic [2:0] alu_op;
   logic [3:0] estado;

   mc_control_unit #(.TIMEOUT(TO), .STW(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_write(ir_write),
      .mdr_write(mdr_write), .pc_load(pc_load), .pc_source(pc_source),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .alu_out_write(alu_out_write), .write_a(write_a), .write_b(write_b),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .error(error), .estado(estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         code;
      bit         req;
      bit         rdy;
      bit         pcl;
      bit         rw;
      logic [2:0] aop;
   } ent_t;

   ent_t tr[$];
   bit   halted;
   bit   expErr;
   int   nErr = 0;
   int   nChk = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int code, input bit req, input bit rdy, input bit pcl,
                       input bit rw, input logic [2:0] aop);
      ent_t e;
      e.code = code; e.req = req; e.rdy = rdy; e.pcl = pcl; e.rw = rw; e.aop = aop;
      tr.push_back(e);
   endtask

   task automatic goHalt(input bit viaException);
      if (viaException) push(13, 0, 0, 0, 0, 0);
      repeat (3) push(14, 0, 0, 0, 0, 0);
      halted = 1;
   endtask

   // A memory access taking 'waits' not-ready cycles before ready.
   task automatic access(input int code, input int waits);
      if (waits >= TO) begin
         repeat (TO) push(code, 1, 0, 0, 0, 0);
         goHalt(1);
      end else begin
         repeat (waits) push(code, 1, 0, 0, 0, 0);
         push(code, 1, 1, code == 1, 0, 0);
      end
   endtask

   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int w1,
                        input int w2, input bit z);
      tr.delete();
      halted = 0;
      opcode = op;
      funct  = fn;
      access(1, w1);
      if (halted) return;
      push(2, 0, 0, 0, 0, 0);
      case (op)
         6'h00: begin
            case (fn)
               6'h20: begin push(7, 0, 0, 0, 0, 3'b001); push(8, 0, 0, 0, 1, 0); end
               6'h22: begin push(7, 0, 0, 0, 0, 3'b010); push(8, 0, 0, 0, 1, 0); end
               6'h24: begin push(7, 0, 0, 0, 0, 3'b011); push(8, 0, 0, 0, 1, 0); end
               6'h26: begin push(7, 0, 0, 0, 0, 3'b110); push(8, 0, 0, 0, 1, 0); end
               6'h0D: goHalt(0);
               default: goHalt(1);
            endcase
         end
         6'h23: begin
            push(3, 0, 0, 0, 0, 0);
            access(4, w2);
            if (!halted) push(5, 0, 0, 0, 1, 0);
         end
         6'h2B: begin push(3, 0, 0, 0, 0, 0); access(6, w2); end
         6'h04: push(9, 0, 0, z, 0, 0);
         6'h02: push(10, 0, 0, 1, 0, 0);
         6'h08: begin push(11, 0, 0, 0, 0, 0); push(12, 0, 0, 0, 1, 0); end
         default: goHalt(1);
      endcase
   endtask

   task automatic run(input int maxN);
      for (int i = 0; i < tr.size() && i < maxN; i++) begin
         @(negedge clk);
         mem_ready = tr[i].req ? tr[i].rdy : 1'($urandom_range(0, 1));
         alu_zero  = (tr[i].code == 9) ? tr[i].pcl : 1'($urandom_range(0, 1));
         if (i > 0 && tr[i-1].code == 13) expErr = 1;
         #2;
         chk("estado", 8'(estado), 8'(tr[i].code));
         chk("mem_req", 8'(mem_req), 8'(tr[i].req));
         chk("mem_wr", 8'(mem_wr), 8'(tr[i].code == 6));
         chk("pc_load", 8'(pc_load), 8'(tr[i].pcl));
         chk("reg_write", 8'(reg_write), 8'(tr[i].rw));
         chk("ir_write", 8'(ir_write), 8'(tr[i].code == 1 && tr[i].rdy));
         chk("mdr_write", 8'(mdr_write), 8'(tr[i].code == 4 && tr[i].rdy));
         chk("error", 8'(error), 8'(expErr));
         if (tr[i].code == 7) chk("alu_op_r", 8'(alu_op), 8'(tr[i].aop));
         if (tr[i].code == 8) chk("reg_dst_r", 8'(reg_dst), 8'd1);
         if (tr[i].code == 9) chk("pc_source_beq", 8'(pc_source), 8'd1);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      expErr = 0;
      #2;
      chk("rst_estado", 8'(estado), 8'd0);
      chk("rst_error", 8'(error), 8'd0);
      chk("rst_mem_req", 8'(mem_req), 8'd0);
      chk("rst_pc_load", 8'(pc_load), 8'd0);
   endtask

   task automatic exec(input logic [5:0] op, input logic [5:0] fn, input int w1,
                       input int w2, input bit z);
      build(op, fn, w1, w2, z);
      run(1000);
      if (halted) doReset();
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [6];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h0D, 6'h3F};
      expErr = 0;
      @(negedge clk);
      doReset();

      exec(6'h00, 6'h20, 0, 0, 0);   // first fetch with immediate ready
      exec(6'h23, 6'h00, 0, 3, 0);   // lw, 3 wait states in MEM_RD
      exec(6'h04, 6'h00, 0, 0, 1);   // beq taken
      exec(6'h04, 6'h00, 1, 0, 0);   // beq not taken
      exec(6'h00, 6'h22, 0, 0, 0);   // sub
      exec(6'h00, 6'h3F, 0, 0, 0);   // illegal funct -> exception, halt
      exec(6'h08, 6'h00, TO, 0, 0);  // fetch timeout
      exec(6'h08, 6'h00, TO - 1, 0, 0); // ready on last allowed cycle
      exec(6'h23, 6'h00, 2, TO, 0);  // MEM_RD timeout
      exec(6'h2B, 6'h00, 0, TO - 1, 0);
      exec(6'h02, 6'h00, 0, 0, 0);
      exec(6'h00, 6'h0D, 0, 0, 0);   // halt without error
      exec(6'h11, 6'h00, 0, 0, 0);   // illegal opcode

      // Reset while waiting in MEM_WR.
      build(6'h2B, 6'h00, 0, 3, 0);
      run(6);
      doReset();

      for (int k = 0; k < 60; k++) begin
         logic [5:0] op, fn;
         int w1, w2;
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         fn = fns[$urandom_range(0, 5)];
         w1 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO - 1)) : TO;
         w2 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO - 1)) : TO;
         exec(op, fn, w1, w2, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end

endmodule
